// File: rtl/bsg_link_ddr_downstream_reset_seq.sv
// Brings a DDR link out of reset: asserts per-channel io resets, waits for the
// io-domain acks, holds, releases, then releases the core link reset.
module bsg_link_ddr_downstream_reset_seq #(
  parameter int num_channels_p     = 1,
  parameter int io_hold_cycles_p   = 32,
  parameter int core_hold_cycles_p = 16,
  parameter int ack_timeout_p      = 1024
) (
  input  logic                      clk_i,
  input  logic                      reset_i,
  input  logic                      start_i,
  input  logic                      restart_i,
  input  logic [num_channels_p-1:0] io_ack_i,
  output logic                      core_link_reset_o,
  output logic [num_channels_p-1:0] io_reset_req_o,
  output logic                      link_up_o,
  output logic                      error_o
);

  localparam int max_hold_lp   = (io_hold_cycles_p > core_hold_cycles_p) ? io_hold_cycles_p : core_hold_cycles_p;
  localparam int max_cycles_lp = (max_hold_lp > ack_timeout_p) ? max_hold_lp : ack_timeout_p;
  localparam int cnt_width_lp  = $clog2(max_cycles_lp) + 1;

  localparam logic [cnt_width_lp-1:0] cnt_zero_lp    = '0;
  localparam logic [cnt_width_lp-1:0] cnt_one_lp     = cnt_width_lp'(1);
  localparam logic [cnt_width_lp-1:0] ack_timeout_lp = cnt_width_lp'(ack_timeout_p);
  localparam logic [cnt_width_lp-1:0] io_hold_lp     = cnt_width_lp'(io_hold_cycles_p);
  localparam logic [cnt_width_lp-1:0] core_hold_lp   = cnt_width_lp'(core_hold_cycles_p);

  typedef enum logic [2:0] {
    e_idle       = 3'd0,
    e_io_assert  = 3'd1,
    e_io_hold    = 3'd2,
    e_io_release = 3'd3,
    e_core_hold  = 3'd4,
    e_up         = 3'd5,
    e_error      = 3'd6
  } state_e;

  state_e                  state_r, state_n;
  logic [cnt_width_lp-1:0] cnt_r, cnt_n;
  logic                    core_reset_n, io_req_n, link_up_n, error_n;

  // Next-state/counter selection and output decode of the next state
  always_comb begin
    state_n = state_r;
    cnt_n   = cnt_r;
    if (restart_i) begin
      state_n = e_io_assert;
      cnt_n   = ack_timeout_lp;
    end else if (!start_i && (state_r != e_idle) && (state_r != e_error)) begin
      state_n = e_idle;
      cnt_n   = cnt_zero_lp;
    end else begin
      case (state_r)
        e_idle: begin
          if (start_i) begin
            state_n = e_io_assert;
            cnt_n   = ack_timeout_lp;
          end else begin
            state_n = e_idle;
          end
        end
        // the ack test comes before the timeout so a same-cycle tie exits cleanly
        e_io_assert: begin
          if (&io_ack_i) begin
            state_n = e_io_hold;
            cnt_n   = io_hold_lp;
          end else if (cnt_r == cnt_zero_lp) begin
            state_n = e_error;
          end else begin
            cnt_n = cnt_r - cnt_one_lp;
          end
        end
        e_io_hold: begin
          if (cnt_r == cnt_one_lp) begin
            state_n = e_io_release;
            cnt_n   = ack_timeout_lp;
          end else begin
            cnt_n = cnt_r - cnt_one_lp;
          end
        end
        e_io_release: begin
          if (~(|io_ack_i)) begin
            state_n = e_core_hold;
            cnt_n   = core_hold_lp;
          end else if (cnt_r == cnt_zero_lp) begin
            state_n = e_error;
          end else begin
            cnt_n = cnt_r - cnt_one_lp;
          end
        end
        e_core_hold: begin
          if (cnt_r == cnt_one_lp) begin
            state_n = e_up;
            cnt_n   = cnt_zero_lp;
          end else begin
            cnt_n = cnt_r - cnt_one_lp;
          end
        end
        e_up:    state_n = e_up;
        e_error: state_n = e_error;
        default: begin
          state_n = e_idle;
          cnt_n   = cnt_zero_lp;
        end
      endcase
    end

    core_reset_n = 1'b1;
    io_req_n     = 1'b0;
    link_up_n    = 1'b0;
    error_n      = 1'b0;
    case (state_n)
      e_io_assert, e_io_hold: io_req_n = 1'b1;
      e_up: begin
        core_reset_n = 1'b0;
        link_up_n    = 1'b1;
      end
      e_error: error_n = 1'b1;
      default: core_reset_n = 1'b1;
    endcase
  end

  // State, counter and registered outputs (outputs track the decoded state)
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_r           <= e_idle;
      cnt_r             <= cnt_zero_lp;
      core_link_reset_o <= 1'b1;
      io_reset_req_o    <= '0;
      link_up_o         <= 1'b0;
      error_o           <= 1'b0;
    end else begin
      state_r           <= state_n;
      cnt_r             <= cnt_n;
      core_link_reset_o <= core_reset_n;
      io_reset_req_o    <= {num_channels_p{io_req_n}};
      link_up_o         <= link_up_n;
      error_o           <= error_n;
    end
  end

endmodule
